// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: request payload toward the arbiter,
// grant and read return back to the requester.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wmask;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with bounded-burst fairness and a
// one-cycle pipelined read return path.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);
  localparam int unsigned      CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             gnt0, gnt1;
  logic             stay;
  logic [CNT_W-1:0] cnt_inc;

  // A lone requester always wins; under contention the owner keeps the bus
  // until it has taken MAX_BURST grants in a row. Reset gates grants directly.
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    state_d     = IDLE;
    burst_cnt_d = '0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    stay        = (burst_cnt_q < BURST_LIM);
    cnt_inc     = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + CNT_W'(1);

    if (rst) begin
      case ({m0.req, m1.req})
        2'b10: gnt0 = 1'b1;
        2'b01: gnt1 = 1'b1;
        2'b11: begin
          case (state_q)
            OWN0: begin
              gnt0 = stay;
              gnt1 = ~stay;
            end
            OWN1: begin
              gnt1 = stay;
              gnt0 = ~stay;
            end
            default: gnt0 = 1'b1;
          endcase
        end
        default: ;
      endcase
    end

    if (gnt0) begin
      state_d     = OWN0;
      burst_cnt_d = (state_q == OWN0) ? cnt_inc : CNT_W'(1);
      rvalid0_d   = ~m0.we;
    end else if (gnt1) begin
      state_d     = OWN1;
      burst_cnt_d = (state_q == OWN1) ? cnt_inc : CNT_W'(1);
      rvalid1_d   = ~m1.we;
    end
  end

  // Memory side follows the granted requester in the same cycle, zero otherwise.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = m0.we;
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
      mem_wmask = m0.wmask;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = m1.we;
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
      mem_wmask = m1.wmask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  // Read data is the memory's registered output, masked to zero outside rvalid.
  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rvalid0_q ? mem_rdata : '0;
  assign m1.rdata  = rvalid1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a driver predicts each cycle's
// grant and read returns from the arbitration rules; a monitor checks them.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned N_RAND    = 3000;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wmask;
  } txn_t;

  typedef struct packed {
    logic              g0;
    logic              g1;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wmask;
    logic [3:0]        cnt;
  } cyc_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } rd_exp_t;

  localparam txn_t IDLE_T = '0;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) m0_if ();
  mem_arbiter_if #(.ADDR_W(ADDR_W)) m1_if ();

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_rdata = '0;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] cyc      = '0;

  cyc_exp_t exp_q[$];
  rd_exp_t  rdq0[$];
  rd_exp_t  rdq1[$];

  // Reference arbitration state: who was granted last cycle and how many times in a row.
  int last_owner = -1;
  int run_len    = 0;

  // Contention pattern from IDLE, encoded {m1_gnt, m0_gnt}.
  logic [1:0] exp_seq [9];

  function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(32'h10C)) return 32'hDEADBEEF;
    return 32'(a) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic txn_t mk(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask);
    txn_t t;
    t.req   = 1'b1;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.wmask = wmask;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, 4'($urandom));
  endfunction

  // Memory device: registered read data, garbage when no read was strobed.
  always @(posedge clk) begin
    cyc       <= cyc + 32'd1;
    mem_rdata <= (mem_en && !mem_we) ? mem_fn(mem_addr) : $urandom;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic reset_model();
    last_owner = -1;
    run_len    = 0;
    rdq0.delete();
    rdq1.delete();
  endtask

  // One clock cycle of stimulus plus the predicted response for it.
  task automatic drive_cycle(input logic rstv, input txn_t t0, input txn_t t1, output int g);
    cyc_exp_t e;
    rd_exp_t  r;
    txn_t     tg;
    @(posedge clk);
    #1;
    rst          = rstv;
    m0_if.req    = t0.req;
    m0_if.we     = t0.we;
    m0_if.addr   = t0.addr;
    m0_if.wdata  = t0.wdata;
    m0_if.wmask  = t0.wmask;
    m1_if.req    = t1.req;
    m1_if.we     = t1.we;
    m1_if.addr   = t1.addr;
    m1_if.wdata  = t1.wdata;
    m1_if.wmask  = t1.wmask;
    if (!rstv) reset_model();
    e     = '0;
    e.cnt = 4'(run_len);
    g     = -1;
    if (rstv) begin
      if (t0.req && t1.req) begin
        if (last_owner < 0)                g = 0;
        else if (run_len < int'(MAX_BURST)) g = last_owner;
        else                               g = 1 - last_owner;
      end else if (t0.req) begin
        g = 0;
      end else if (t1.req) begin
        g = 1;
      end
    end
    if (g >= 0) begin
      tg      = (g == 0) ? t0 : t1;
      e.g0    = (g == 0);
      e.g1    = (g == 1);
      e.en    = 1'b1;
      e.we    = tg.we;
      e.addr  = tg.addr;
      e.wdata = tg.wdata;
      e.wmask = tg.wmask;
      if (!tg.we) begin
        r.data = mem_fn(tg.addr);
        r.due  = cyc + 32'd1;
        if (g == 0) rdq0.push_back(r);
        else        rdq1.push_back(r);
      end
      if (g == last_owner) begin
        run_len = (run_len < 15) ? run_len + 1 : 15;
      end else begin
        last_owner = g;
        run_len    = 1;
      end
    end else begin
      last_owner = -1;
      run_len    = 0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle's grant/memory side and every read return.
  always @(negedge clk) begin
    cyc_exp_t e;
    rd_exp_t  r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt",       64'({m0_if.gnt, m1_if.gnt}), 64'({e.g0, e.g1}));
      check("mem_en",    64'(mem_en),               64'(e.en));
      check("mem_we",    64'(mem_we),               64'(e.we));
      check("mem_addr",  64'(mem_addr),             64'(e.addr));
      check("mem_wdata", 64'(mem_wdata),            64'(e.wdata));
      check("mem_wmask", 64'(mem_wmask),            64'(e.wmask));
      check("burst_cnt", 64'(dut.burst_cnt_q),      64'(e.cnt));
    end
    if (rdq0.size() > 0 && rdq0[0].due == cyc) begin
      r = rdq0.pop_front();
      check("m0_rvalid", 64'(m0_if.rvalid), 64'(1));
      check("m0_rdata",  64'(m0_if.rdata),  64'(r.data));
    end else begin
      check("m0_rvalid_idle", 64'(m0_if.rvalid), 64'(0));
      check("m0_rdata_idle",  64'(m0_if.rdata),  64'(0));
    end
    if (rdq1.size() > 0 && rdq1[0].due == cyc) begin
      r = rdq1.pop_front();
      check("m1_rvalid", 64'(m1_if.rvalid), 64'(1));
      check("m1_rdata",  64'(m1_if.rdata),  64'(r.data));
    end else begin
      check("m1_rvalid_idle", 64'(m1_if.rvalid), 64'(0));
      check("m1_rdata_idle",  64'(m1_if.rdata),  64'(0));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int   g;
    txn_t a;
    txn_t b;
    txn_t p0;
    txn_t p1;
    logic rv;

    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    // Held in reset with both requesting: nothing may be granted, before any edge.
    rst = 1'b0;
    a   = mk(1'b0, 32'h1000, 32'h0, 4'h0);
    b   = mk(1'b0, 32'h2000, 32'h0, 4'h0);
    m0_if.req = a.req; m0_if.we = a.we; m0_if.addr = a.addr; m0_if.wdata = a.wdata; m0_if.wmask = a.wmask;
    m1_if.req = b.req; m1_if.we = b.we; m1_if.addr = b.addr; m1_if.wdata = b.wdata; m1_if.wmask = b.wmask;
    #2;
    check("rst_gnt",    64'({m0_if.gnt, m1_if.gnt}),       64'(0));
    check("rst_mem_en", 64'(mem_en),                       64'(0));
    check("rst_rvalid", 64'({m0_if.rvalid, m1_if.rvalid}), 64'(0));
    check("rst_rdata",  64'({m0_if.rdata, m1_if.rdata}),   64'(0));
    drive_cycle(1'b0, a, b, g);
    drive_cycle(1'b0, a, b, g);

    // Continuous contention from IDLE: four grants each, alternating.
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b1, a, b, g);
      #1;
      check("contention_seq", 64'({m1_if.gnt, m0_if.gnt}), 64'(exp_seq[i]));
      if (g == 0) a.addr = a.addr + ADDR_W'(4);
      if (g == 1) b.addr = b.addr + ADDR_W'(4);
    end
    drive_cycle(1'b1, IDLE_T, IDLE_T, g);
    drive_cycle(1'b1, IDLE_T, IDLE_T, g);

    // Single read by m1.
    drive_cycle(1'b1, IDLE_T, mk(1'b0, 32'h10C, 32'h0, 4'h0), g);
    #1;
    check("single_read_gnt", 64'({m1_if.gnt, m0_if.gnt}), 64'(2'b10));
    drive_cycle(1'b1, IDLE_T, IDLE_T, g);
    #1;
    check("single_read_rvalid", 64'({m1_if.rvalid, m0_if.rvalid}), 64'(2'b10));
    check("single_read_rdata",  64'(m1_if.rdata),                  64'(32'hDEADBEEF));

    // Write passthrough by m0.
    drive_cycle(1'b1, mk(1'b1, 32'h1D4, 32'h12345678, 4'h3), IDLE_T, g);
    #1;
    check("write_mem", 64'({mem_en, mem_we, mem_wmask, mem_addr}), 64'({1'b1, 1'b1, 4'h3, 32'h1D4}));
    check("write_wdata", 64'(mem_wdata), 64'(32'h12345678));
    drive_cycle(1'b1, IDLE_T, IDLE_T, g);
    #1;
    check("write_no_rvalid", 64'({m1_if.rvalid, m0_if.rvalid}), 64'(0));

    // Pipelined reads 0x100, 0x104, 0x108.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_cycle(1'b1, mk(1'b0, ADDR_W'(32'h100 + 4 * i), 32'h0, 4'h0), IDLE_T, g);
      else       drive_cycle(1'b1, IDLE_T, IDLE_T, g);
      #1;
      if (i > 0) begin
        check("pipe_rvalid", 64'(m0_if.rvalid), 64'(1));
        check("pipe_rdata",  64'(m0_if.rdata),  64'(mem_fn(ADDR_W'(32'h100 + 4 * (i - 1)))));
      end
    end

    // Reset arriving between a read grant and its return edge.
    a = mk(1'b0, 32'h200, 32'h0, 4'h0);
    drive_cycle(1'b1, a, IDLE_T, g);
    @(negedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    #1;
    check("midrst_gnt",    64'({m0_if.gnt, m1_if.gnt}), 64'(0));
    check("midrst_mem",    64'({mem_en, mem_we, mem_addr, mem_wmask}), 64'(0));
    check("midrst_rvalid", 64'(m0_if.rvalid), 64'(0));
    drive_cycle(1'b0, a, IDLE_T, g);
    #1;
    check("midrst_rvalid_after_edge", 64'(m0_if.rvalid), 64'(0));
    check("midrst_rdata_after_edge",  64'(m0_if.rdata),  64'(0));
    drive_cycle(1'b1, a, mk(1'b0, 32'h300, 32'h0, 4'h0), g);
    #1;
    check("release_from_idle", 64'({m1_if.gnt, m0_if.gnt}), 64'(2'b01));
    drive_cycle(1'b1, IDLE_T, IDLE_T, g);

    // Randomized traffic; requesters hold a transaction until it is granted.
    p0 = IDLE_T;
    p1 = IDLE_T;
    repeat (N_RAND) begin
      if (!p0.req && $urandom_range(0, 3) != 0) p0 = rnd_txn();
      if (!p1.req && $urandom_range(0, 2) != 0) p1 = rnd_txn();
      rv = ($urandom_range(0, 199) != 0);
      drive_cycle(rv, p0, p1, g);
      if (g == 0) p0.req = 1'b0;
      if (g == 1) p1.req = 1'b0;
    end

    repeat (3) drive_cycle(1'b1, IDLE_T, IDLE_T, g);
    @(negedge clk);
    #1;
    check("reads_outstanding", 64'(rdq0.size() + rdq1.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte address width for both requesters and the memory side.
REQ-002 Parameter: MAX_BURST, default 4, range 1..15, maximum consecutive grants to one requester while the other is requesting.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 Port: m0_req, m1_req  input  1 each  access request; m0 = CPU data port, m1 = loader/debug port.
REQ-006 Port: m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-007 Port: m0_addr, m1_addr  input  ADDR_W each  byte address.
REQ-008 Port: m0_wdata, m1_wdata  input  32 each  write data.
REQ-009 Port: m0_wmask, m1_wmask  input  4 each  byte-lane write enables.
REQ-010 Port: m0_gnt, m1_gnt  output  1 each  request accepted this cycle (combinational).
REQ-011 Port: m0_rvalid, m1_rvalid  output  1 each  read data valid (registered).
REQ-012 Port: m0_rdata, m1_rdata  output  32 each  read data.
REQ-013 Port: mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-014 Port: mem_addr  output  ADDR_W  memory byte address.
REQ-015 Port: mem_wdata, mem_wmask  output  32, 4  memory write data and byte mask.
REQ-016 Port: mem_rdata  input  32  memory read data, valid one cycle after a read strobe.

Function
REQ-017 A transfer SHALL occur on every cycle where mx_req and mx_gnt are both 1; the requester SHALL hold we/addr/wdata/wmask stable until granted.
REQ-018 At most one of m0_gnt, m1_gnt SHALL be 1 in any cycle; a gnt SHALL never assert without its req.
REQ-019 The FSM SHALL have states IDLE (no grant last cycle), OWN0 (m0 granted last cycle) and OWN1 (m1 granted last cycle); the next state is the requester granted this cycle, or IDLE if none.
REQ-020 If exactly one requester is requesting, it SHALL be granted regardless of state or burst count.
REQ-021 If both request in IDLE, m0 SHALL be granted.
REQ-022 If both request in OWNx, x SHALL be granted while burst_cnt < MAX_BURST; otherwise the other requester SHALL be granted.
REQ-023 burst_cnt (4 bits) SHALL load 1 on a grant to a different requester than last cycle or from IDLE, increment on a repeat grant, saturate at 15, and clear to 0 in IDLE.
REQ-024 While a grant is active, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata/mem_wmask SHALL equal the granted requester's signals in the same cycle.
REQ-025 With no grant, mem_en, mem_we, mem_addr, mem_wdata and mem_wmask SHALL all be 0.
REQ-026 A granted read SHALL assert that requester's rvalid for exactly one cycle, the cycle after the grant, with rdata = mem_rdata; a granted write SHALL produce no rvalid.
REQ-027 Back-to-back reads SHALL be pipelined: one read per cycle, rvalid streaming with 1-cycle latency, ordered.
REQ-028 mx_rdata SHALL be 0 when mx_rvalid = 0.
REQ-029 Addresses SHALL be forwarded unmodified; alignment is the requester's responsibility.

Reset
REQ-030 While rst = 0: state = IDLE, burst_cnt = 0, m0_rvalid = m1_rvalid = 0, rdata outputs 0, no gnt asserted, all mem_* outputs 0, independent of clk.
REQ-031 Reset assertion mid-transfer SHALL drop a pending rvalid immediately; after release, the first cycle arbitrates from IDLE.

Verification
REQ-032 Reset: rst = 0 with both req = 1 -> no gnt, mem_en = 0, rvalid = 0; release -> m0_gnt = 1 on the first edge-aligned cycle.
REQ-033 Single read: m1 reads addr 0x10C, memory returns 0xDEADBEEF -> m1_gnt the same cycle, m1_rvalid = 1 and m1_rdata = 0xDEADBEEF the next cycle, m0_rvalid = 0.
REQ-034 Contention with MAX_BURST = 4: both requesters hold req continuously from IDLE -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0,... and burst_cnt follows 1,2,3,4,1,2,3,4,1.
REQ-035 Write passthrough: m0 writes 0x12345678, mask 0x3, to 0x1D4 -> mem_en = 1, mem_we = 1, mem_addr = 0x1D4, mem_wmask = 0x3 the same cycle; no rvalid.
REQ-036 Pipelined reads: m0 reads 0x100, 0x104, 0x108 on consecutive cycles -> three consecutive rvalid cycles with data in the same order.
REQ-037 Reset during read: read granted, rst = 0 before the next edge -> m0_rvalid stays 0 and all outputs return to reset values.
